// File: rtl/dbg_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbg_pkg : debug command encodings and arbiter state type shared by the debug taps
// Rev 1.0
// -----------------------------------------------------------------------------
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ABORT = 2'd2,
        ST_RESP  = 2'd3
    } dbg_arb_state_e;

    localparam logic [7:0] DBG_CMD_NONE  = 8'h00;
    localparam int         DBG_CMD_MEM   = 7;
    localparam int         DBG_CMD_WRITE = 6;
    localparam logic [7:0] DBG_END       = 8'haa;

endpackage
`default_nettype wire

// File: rtl/dbg_rr_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbg_rr_pick : combinational round-robin picker, first request at or after i_ptr
// Rev 1.0
// -----------------------------------------------------------------------------
module dbg_rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    int          w_c;
    logic [PW-1:0] w_ci;

    // Wrap by subtraction so non-power-of-two N never indexes past N-1.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        w_ci  = '0;
        for (int i = 0; i < N; i++) begin
            w_c = int'(i_ptr) + i;
            if (w_c >= N) begin
                w_c = w_c - N;
            end
            w_ci = PW'(w_c);
            if (!o_any && i_req[w_ci]) begin
                o_any       = 1'b1;
                o_gnt[w_ci] = 1'b1;
                o_idx       = w_ci;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbg_cmd_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dbg_cmd_arbiter : shares the dbg_module command port between debug front-ends
// Rev 1.0
// -----------------------------------------------------------------------------
module dbg_cmd_arbiter
    import dbg_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0][7:0]    req_cmd_i,
    input  logic [N_REQ-1:0][31:0]   req_addr_i,
    input  logic [N_REQ-1:0][31:0]   req_data_i,
    input  logic [N_REQ-1:0]         req_lock_i,
    output logic [N_REQ-1:0]         req_gnt_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [31:0]              rsp_data_o,
    output logic                     rsp_err_o,
    output logic [7:0]               dbg_cmd_o,
    output logic [31:0]              dbg_addr_o,
    output logic [31:0]              dbg_data_o,
    input  logic [31:0]              dbg_data_i,
    input  logic                     dbg_ready_i,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     busy_o
);

    localparam int            OW       = $clog2(N_REQ);
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

    dbg_arb_state_e    r_state;
    dbg_arb_state_e    w_next;
    logic [OW-1:0]     r_ptr;
    logic [OW-1:0]     r_owner;
    logic              r_lock;
    logic [CW-1:0]     r_cnt;
    logic [7:0]        r_dbg_cmd;
    logic [31:0]       r_dbg_addr;
    logic [31:0]       r_dbg_data;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;
    logic              r_busy;

    logic              w_locked;
    logic [N_REQ-1:0]  w_own_mask;
    logic [N_REQ-1:0]  w_cand;
    logic [N_REQ-1:0]  w_pick_gnt;
    logic [OW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_grant;
    logic [7:0]        w_sel_cmd;
    logic              w_timeout;
    logic [OW-1:0]     w_rsp_owner;
    logic [31:0]       w_rsp_data;
    logic              w_rsp_err;

    always_comb begin
        w_own_mask          = '0;
        w_own_mask[r_owner] = 1'b1;
    end

    // A lock that the owner has released no longer filters this cycle's arbitration.
    assign w_locked  = r_lock & req_lock_i[r_owner];
    assign w_cand    = w_locked ? (req_valid_i & w_own_mask) : req_valid_i;
    assign w_grant   = (r_state == ST_IDLE) && w_pick_any;
    assign w_sel_cmd = req_cmd_i[w_pick_idx];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    dbg_rr_pick #(
        .N  (N_REQ),
        .PW (OW)
    ) u_pick (
        .i_req (w_cand),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = (w_sel_cmd == DBG_CMD_NONE) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dbg_ready_i) begin
                    w_next = ST_RESP;
                end else if (w_timeout) begin
                    w_next = ST_ABORT;
                end
            end
            ST_ABORT: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Illegal commands and aborts both answer with err=1 and zero data.
    always_comb begin
        req_gnt_o   = w_grant ? w_pick_gnt : '0;
        w_rsp_owner = (r_state == ST_IDLE) ? w_pick_idx : r_owner;
        w_rsp_data  = '0;
        w_rsp_err   = 1'b1;
        if ((r_state == ST_ISSUE) && dbg_ready_i) begin
            w_rsp_data = dbg_data_i;
            w_rsp_err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_lock      <= 1'b0;
            r_cnt       <= '0;
            r_dbg_cmd   <= DBG_CMD_NONE;
            r_dbg_addr  <= '0;
            r_dbg_data  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy      <= (w_next != ST_IDLE);
            r_rsp_valid <= '0;
            r_cnt       <= (r_state == ST_ISSUE) ? r_cnt + 1'b1 : '0;

            if (w_grant) begin
                r_owner    <= w_pick_idx;
                r_dbg_cmd  <= w_sel_cmd;
                r_dbg_addr <= req_addr_i[w_pick_idx];
                r_dbg_data <= req_data_i[w_pick_idx];
                if (!w_locked) begin
                    r_ptr <= (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
                end
            end else if (w_next != ST_ISSUE) begin
                r_dbg_cmd <= DBG_CMD_NONE;
            end

            if (w_next == ST_RESP) begin
                r_rsp_valid[w_rsp_owner] <= 1'b1;
                r_rsp_data               <= w_rsp_data;
                r_rsp_err                <= w_rsp_err;
            end

            if (r_state == ST_RESP) begin
                r_lock <= req_lock_i[r_owner];
            end else if ((r_state == ST_IDLE) && !req_lock_i[r_owner]) begin
                r_lock <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign dbg_cmd_o   = r_dbg_cmd;
    assign dbg_addr_o  = r_dbg_addr;
    assign dbg_data_o  = r_dbg_data;
    assign owner_o     = r_owner;
    assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: doc/dbg_cmd_arbiter.md
# dbg_cmd_arbiter

Shares the single command port of `dbg_module` between several debug front-ends, such as the UART tap and a future JTAG tap. Each requester presents a complete command (cmd, addr, data). The arbiter grants round-robin and drives `dbg_module` until `ready`. It then returns read data and a done/error pulse to the owner. Optional lock keeps ownership across multi-command sequences (halt, write, resume). A timeout aborts commands that never complete.

## Interface
- `N_REQ`, 2: number of requesters (≥2).
- `TIMEOUT`, 1024: max cycles in ISSUE before abort; 0 disables timeout.
- `clk` in 1: clock.
- `rstn_i` in 1: reset, synchronous, active-low.
- `req_valid_i` in [N_REQ]: command pending; held with cmd/addr/data stable until `req_gnt_o`.
- `req_cmd_i` in [N_REQ][8]: debug command; bit7 = memory op, bit6 = write.
- `req_addr_i` in [N_REQ][32]: address for memory ops.
- `req_data_i` in [N_REQ][32]: write data.
- `req_lock_i` in [N_REQ]: requester wants to keep ownership after its response.
- `req_gnt_o` out [N_REQ]: one-cycle pulse, command accepted and latched.
- `rsp_valid_o` out [N_REQ]: one-cycle pulse to owner, command finished.
- `rsp_data_o` out 32: read data, valid with `rsp_valid_o`.
- `rsp_err_o` out 1: timeout or illegal cmd, valid with `rsp_valid_o`.
- `dbg_cmd_o` out 8: to `dbg_module.cmd_i`; 0 = no command.
- `dbg_addr_o` out 32: to `dbg_module.addr_i`.
- `dbg_data_o` out 32: to `dbg_module.data_i`.
- `dbg_data_i` in 32: from `dbg_module.data_o`.
- `dbg_ready_i` in 1: from `dbg_module.ready_o`.
- `owner_o` out $clog2(N_REQ): current or last owner index.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: pick a requester.
  - ISSUE: command presented to `dbg_module`.
  - ABORT: one cycle with `dbg_cmd_o` = 0 after a timeout.
  - RESP: one cycle, response pulse to owner.
- IDLE, unlocked:
  - Candidates are requesters with `req_valid_i`.
  - Winner is the first candidate at or after the priority pointer `ptr`, modulo N_REQ.
  - Assert `req_gnt_o[win]`, latch cmd/addr/data, set `owner`, set `ptr` = win+1 mod N_REQ.
  - If the latched cmd ≠ 0, go to ISSUE. If cmd = 0 (illegal), go to RESP with err=1; `dbg_module` is never touched.
- IDLE, locked:
  - Only `owner` may be granted; all others are ignored. `ptr` is unchanged.
  - Lock clears in any IDLE cycle where `req_lock_i[owner]` = 0. Arbitration in that same cycle is unlocked.
- ISSUE:
  - `dbg_cmd_o` = latched cmd; addr/data outputs held.
  - `dbg_ready_i` = 1: capture `dbg_data_i` into the response register, err=0, go to RESP.
  - Otherwise, if TIMEOUT ≠ 0 and the counter reaches TIMEOUT-1: err=1, response data = 0, go to ABORT.
- ABORT: `dbg_cmd_o` = 0 for one cycle, then go to RESP.
- RESP:
  - `rsp_valid_o[owner]` = 1, `dbg_cmd_o` = 0.
  - Lock is set if `req_lock_i[owner]` = 1.
  - Go to IDLE.
- `dbg_cmd_o` is non-zero only in ISSUE. This guarantees at least one zero cycle between consecutive commands.
- `rsp_data_o` and `rsp_err_o` hold their values until the next RESP.

## Timing
- All outputs are registered except `req_gnt_o`, which is combinational from IDLE state and `req_valid_i`.
- Grant in cycle T → `dbg_cmd_o` valid at T+1.
- `dbg_ready_i` seen at cycle R → `rsp_valid_o` at R+1 and `dbg_cmd_o` = 0 at R+1.
- Next grant no earlier than R+2.
- Minimum grant-to-grant spacing is 3 cycles.
- Timeout: `rsp_valid_o` with err=1 at T+TIMEOUT+2.
- A requester asserting valid during ISSUE or RESP waits; no grant is issued outside IDLE.
- Reset, asserted at any time including mid-ISSUE, applies at the next edge:
  - state IDLE, `ptr` 0, lock cleared, owner 0;
  - all gnt/rsp/dbg outputs 0, `busy_o` 0;
  - the in-flight command is dropped with no response.
- Width rules: timeout counter is $clog2(TIMEOUT+1) bits. `ptr` and owner wrap modulo N_REQ; this must be correct for non-power-of-two N_REQ.

## Structure
- Shared `dbg_pkg` holds:
  - the state enum;
  - `DBG_CMD_NONE` = 8'h00;
  - cmd bit positions `DBG_CMD_MEM` = 7 and `DBG_CMD_WRITE` = 6;
  - `DBG_END` = 8'haa.
  - The UART tap also imports these.
- Sub-module `dbg_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable by future arbiters.
- Top level holds the FSM, command/response registers, lock flag and timeout counter.

## Test plan
- Single read:
  - Stimulus: req0 cmd 8'h80, addr 32'h1000; `dbg_module` model returns 32'hDEADBEEF with `dbg_ready_i` 4 cycles after issue.
  - Required: one gnt pulse; `dbg_cmd_o` = 8'h80 for exactly 4 cycles; `rsp_valid_o[0]` with data DEADBEEF, err 0.
- Contention:
  - Stimulus: req0 and req1 both hold valid continuously after reset.
  - Required: grant order 0,1,0,1; `dbg_cmd_o` returns to 0 between every command.
- Lock:
  - Stimulus: req1 with lock=1 issues three commands while req0 stays valid.
  - Required: req0 receives no grant until req1 drops lock in IDLE; the next grant goes to req0.
- Timeout:
  - Stimulus: TIMEOUT=8; model never asserts ready.
  - Required: `dbg_cmd_o` non-zero for 8 cycles, then 0; `rsp_valid_o` with err=1, data 0; arbiter back in IDLE.
- Illegal and reset:
  - Stimulus A: cmd 8'h00.
  - Required A: gnt then rsp err=1, `dbg_cmd_o` never non-zero.
  - Stimulus B: `rstn_i` low for one cycle mid-ISSUE.
  - Required B: next cycle all outputs 0, `busy_o` 0, no rsp pulse; next grant goes to req0.
